// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite transfer-type and transfer-size encodings shared by AHB slaves.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/flexdbg_pkg.sv
// Register map, FSM state type and byte-lane helpers for the debugger CSR slave.
package flexdbg_pkg;

   import ahb3lite_pkg::*;

   localparam int unsigned OW = 8;

   localparam logic [31:0] ID_VALUE   = 32'hF1EC_DB61;
   localparam logic [15:0] CLKDIV_RST = 16'd4;

   localparam logic [OW-1:0] CSR_ID      = 8'h00;
   localparam logic [OW-1:0] CSR_CTRL    = 8'h04;
   localparam logic [OW-1:0] CSR_CLKDIV  = 8'h08;
   localparam logic [OW-1:0] CSR_DROPPED = 8'h0C;
   localparam logic [OW-1:0] CSR_SCRATCH = 8'h10;

   // IDLE: nothing pending; DATA: zero-wait OKAY data phase;
   // ERR1/ERR2: the two cycles of an AHB ERROR response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_e;

   typedef struct packed {
      logic jtag_direct;
      logic jtagnswd;
   } ctrl_t;

   // Byte lanes touched by a transfer of the given size at the given address.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << addr;
         HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replace the enabled byte lanes of old_val with those of new_val.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/flexdbg_csr_ahb3.sv
// AHB3-Lite CSR slave for the debugger: ID, CTRL, CLKDIV, DROPPED, SCRATCH.
// Handshake: an address phase is taken when HSEL && HREADY && HTRANS[1];
// its data phase is the next cycle, completing when HREADYOUT=1. Good
// transfers are zero wait; bad ones get a two-cycle ERROR (HREADYOUT 0 then 1).
module flexdbg_csr_ahb3
   import ahb3lite_pkg::*;
   import flexdbg_pkg::*;
(
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   input  logic [9:0]  DROPPED,
   output logic        JTAGNSWD,
   output logic        JTAG_DIRECT,
   output logic [15:0] CLKDIV,
   output logic [1:0]  dbg_state
);

   state_e          state_q, state_d;
   logic [OW-1:0]   addr_q, addr_d;
   logic            write_q, write_d;
   logic [2:0]      size_q, size_d;
   logic            hreadyout_q, hreadyout_d;
   logic            hresp_q, hresp_d;

   ctrl_t           ctrl_q, ctrl_d;
   logic [15:0]     clkdiv_q, clkdiv_d;
   logic [31:0]     scratch_q, scratch_d;

   logic            accept;
   logic            a_err;
   logic [OW-1:0]   a_reg;
   logic [OW-1:0]   d_reg;
   logic            wr_en;
   logic [3:0]      wr_mask;
   logic [31:0]     ctrl_m, clkdiv_m;
   logic [31:0]     rd_val;

   // Routing is upstream, so the high address bits and burst/prot carry nothing here.
   logic            unused_ok;
   assign unused_ok = ^{HADDR[31:OW], HBURST, HPROT};

   // Address-phase decode: acceptance and the error classification of the transfer.
   always_comb begin
      accept = HSEL && HREADY && HTRANS[1];
      a_reg  = {HADDR[OW-1:2], 2'b00};
      a_err  = 1'b0;
      if (HADDR[OW-1:2] > 6'd4)                                   a_err = 1'b1;
      if (HWRITE && (a_reg == CSR_ID || a_reg == CSR_DROPPED))    a_err = 1'b1;
      if (HSIZE > HSIZE_WORD)                                     a_err = 1'b1;
      if (HSIZE == HSIZE_HALF && HADDR[0])                        a_err = 1'b1;
      if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)             a_err = 1'b1;
   end

   // Next state, captured address-phase fields and registered response outputs.
   always_comb begin
      state_d = ST_IDLE;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
      end else if (accept) begin
         state_d = a_err ? ST_ERR1 : ST_DATA;
         addr_d  = HADDR[OW-1:0];
         write_d = HWRITE;
         size_d  = HSIZE;
      end
      hreadyout_d = (state_d != ST_ERR1);
      hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
   end

   // Bus FSM with its registered HREADYOUT/HRESP.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= HSIZE_BYTE;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         size_q      <= size_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Data-phase write merge; only good transfers ever reach ST_DATA.
   always_comb begin
      d_reg     = {addr_q[OW-1:2], 2'b00};
      wr_en     = (state_q == ST_DATA) && write_q;
      wr_mask   = lane_mask(size_q, addr_q[1:0]);
      ctrl_m    = merge_lanes({30'd0, ctrl_q}, HWDATA, wr_mask);
      clkdiv_m  = merge_lanes({16'd0, clkdiv_q}, HWDATA, wr_mask);
      ctrl_d    = ctrl_q;
      clkdiv_d  = clkdiv_q;
      scratch_d = scratch_q;
      if (wr_en) begin
         case (d_reg)
            CSR_CTRL:    ctrl_d    = ctrl_t'(ctrl_m[1:0]);
            CSR_CLKDIV:  clkdiv_d  = (clkdiv_m[15:0] == 16'd0) ? 16'd1 : clkdiv_m[15:0];
            CSR_SCRATCH: scratch_d = merge_lanes(scratch_q, HWDATA, wr_mask);
            default:     ;
         endcase
      end
   end

   // Register file.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         ctrl_q    <= '0;
         clkdiv_q  <= CLKDIV_RST;
         scratch_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         clkdiv_q  <= clkdiv_d;
         scratch_q <= scratch_d;
      end
   end

   // Read mux; DROPPED is live, not snapshotted at the address phase.
   always_comb begin
      case (d_reg)
         CSR_ID:      rd_val = ID_VALUE;
         CSR_CTRL:    rd_val = {30'd0, ctrl_q};
         CSR_CLKDIV:  rd_val = {16'd0, clkdiv_q};
         CSR_DROPPED: rd_val = {22'd0, DROPPED};
         CSR_SCRATCH: rd_val = scratch_q;
         default:     rd_val = 32'd0;
      endcase
      HRDATA = (state_q == ST_DATA && !write_q) ? rd_val : 32'd0;
   end

   assign HREADYOUT   = hreadyout_q;
   assign HRESP       = hresp_q;
   assign JTAGNSWD    = ctrl_q.jtagnswd;
   assign JTAG_DIRECT = ctrl_q.jtag_direct;
   assign CLKDIV      = clkdiv_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_flexdbg_csr_ahb3.sv
// Directed plus randomized bench for flexdbg_csr_ahb3 against a byte-level register model.
module tb_flexdbg_csr_ahb3;

   import ahb3lite_pkg::*;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = HTRANS_IDLE;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = '0;
   logic [2:0]  HBURST = '0;
   logic [3:0]  HPROT = '0;
   logic [31:0] HWDATA = '0;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [9:0]  DROPPED = '0;
   logic        JTAGNSWD;
   logic        JTAG_DIRECT;
   logic [15:0] CLKDIV;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_ctrl, m_clkdiv, m_scratch;

   // Single-slave bus: the bus-wide ready is this slave's ready.
   assign HREADY = HREADYOUT;

   flexdbg_csr_ahb3 dut (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .HSEL        (HSEL),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HBURST      (HBURST),
      .HPROT       (HPROT),
      .HWDATA      (HWDATA),
      .HREADY      (HREADY),
      .HREADYOUT   (HREADYOUT),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .DROPPED     (DROPPED),
      .JTAGNSWD    (JTAGNSWD),
      .JTAG_DIRECT (JTAG_DIRECT),
      .CLKDIV      (CLKDIV),
      .dbg_state   (dbg_state)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic m_reset();
      m_ctrl    = 32'd0;
      m_clkdiv  = 32'd4;
      m_scratch = 32'd0;
   endtask

   function automatic logic m_err(input logic [31:0] a, input logic w, input logic [2:0] sz);
      int off;
      logic bad;
      off = int'(a[7:0]);
      bad = 1'b0;
      if (off >= 20) bad = 1'b1;
      if (w && (off / 4 == 0 || off / 4 == 3)) bad = 1'b1;
      if (sz > 2) bad = 1'b1;
      if (sz == 1 && off % 2 != 0) bad = 1'b1;
      if (sz == 2 && off % 4 != 0) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (int'(a[7:0]) / 4)
         0:       return 32'hF1EC_DB61;
         1:       return m_ctrl;
         2:       return m_clkdiv;
         3:       return {22'd0, DROPPED};
         4:       return m_scratch;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      logic [31:0] v;
      int first, nbytes, lane;
      v      = m_read(a);
      first  = int'(a[1:0]);
      nbytes = 1 << sz;
      for (int k = 0; k < nbytes; k++) begin
         lane = first + k;
         v[lane*8 +: 8] = d[lane*8 +: 8];
      end
      case (int'(a[7:0]) / 4)
         1: m_ctrl = v & 32'h3;
         2: begin
            m_clkdiv = v & 32'hFFFF;
            if (m_clkdiv == 0) m_clkdiv = 1;
         end
         4: m_scratch = v;
         default: ;
      endcase
   endtask

   task automatic chk_pins(input string tag);
      chk({tag, "/jtagnswd"}, {31'd0, JTAGNSWD}, {31'd0, m_ctrl[0]});
      chk({tag, "/jtag_direct"}, {31'd0, JTAG_DIRECT}, {31'd0, m_ctrl[1]});
      chk({tag, "/clkdiv"}, {16'd0, CLKDIV}, m_clkdiv);
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HADDR  = $urandom;
   endtask

   // One non-pipelined transfer, fully checked against the model.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr, input string tag);
      logic acc, e;
      HSEL   = 1'b1;
      HADDR  = a;
      HWRITE = w;
      HSIZE  = sz;
      HTRANS = tr;
      HBURST = 3'($urandom);
      HPROT  = 4'($urandom);
      acc = tr[1];
      e   = acc && m_err(a, w, sz);
      step();
      bus_idle();
      HWDATA = wd;
      if (e) begin
         chk({tag, "/err1_ready"}, {31'd0, HREADYOUT}, 32'd0);
         chk({tag, "/err1_resp"}, {31'd0, HRESP}, 32'd1);
         chk({tag, "/err1_rdata"}, HRDATA, 32'd0);
         step();
         chk({tag, "/err2_ready"}, {31'd0, HREADYOUT}, 32'd1);
         chk({tag, "/err2_resp"}, {31'd0, HRESP}, 32'd1);
         step();
         chk({tag, "/post_resp"}, {31'd0, HRESP}, 32'd0);
         chk_pins({tag, "/post"});
      end else begin
         chk({tag, "/ready"}, {31'd0, HREADYOUT}, 32'd1);
         chk({tag, "/resp"}, {31'd0, HRESP}, 32'd0);
         chk({tag, "/rdata"}, HRDATA, (acc && !w) ? m_read(a) : 32'd0);
         step();
         if (acc && w) m_write(a, wd, sz);
         step();
         chk_pins({tag, "/pins"});
      end
   endtask

   initial begin
      logic [31:0] a, d;
      logic [2:0]  sz;
      logic [1:0]  tr;
      logic [7:0]  off;

      // Reset
      m_reset();
      repeat (2) @(negedge CLK);
      #2 RESETn = 1'b1;
      @(negedge CLK);
      chk("reset/ready", {31'd0, HREADYOUT}, 32'd1);
      chk("reset/resp", {31'd0, HRESP}, 32'd0);
      chk("reset/rdata", HRDATA, 32'd0);
      chk("reset/state", {30'd0, dbg_state}, 32'd0);
      chk_pins("reset");

      // Reset-value reads of every register
      DROPPED = 10'($urandom_range(1, 1023));
      xfer(32'hF000_0000, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_id");
      xfer(32'hF000_0004, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_ctrl");
      xfer(32'hF000_0008, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_clkdiv");
      xfer(32'hF000_000C, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_dropped");
      xfer(32'hF000_0010, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_scratch");

      // Back-to-back CTRL write then read
      HSEL = 1'b1; HADDR = 32'hF000_0004; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      step();
      chk("b2b/wr_ready", {31'd0, HREADYOUT}, 32'd1);
      HWDATA = 32'h0000_0003; HWRITE = 1'b0;
      step();
      m_write(32'h4, 32'h3, HSIZE_WORD);
      chk("b2b/rd_ready", {31'd0, HREADYOUT}, 32'd1);
      chk("b2b/rd_resp", {31'd0, HRESP}, 32'd0);
      chk("b2b/rdata", HRDATA, 32'h3);
      bus_idle();
      step();
      chk("b2b/jtagnswd", {31'd0, JTAGNSWD}, 32'd1);
      chk("b2b/jtag_direct", {31'd0, JTAG_DIRECT}, 32'd1);

      // SCRATCH byte merge and CLKDIV zero write
      xfer(32'hF000_0010, 1'b1, HSIZE_WORD, 32'h1122_3344, HTRANS_NONSEQ, "wr_scr");
      xfer(32'hF000_0012, 1'b1, HSIZE_BYTE, 32'h55AB_6677, HTRANS_NONSEQ, "wr_scr_b2");
      xfer(32'hF000_0010, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_scr");
      chk("scr_const", m_scratch, 32'h11AB_3344);
      xfer(32'hF000_0008, 1'b1, HSIZE_HALF, 32'hBEEF_0000, HTRANS_NONSEQ, "wr_clkdiv0");
      chk("clkdiv_zero_as_one", {16'd0, CLKDIV}, 32'd1);
      xfer(32'hF000_0008, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rd_clkdiv1");

      // Error responses
      xfer(32'hF000_0000, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, HTRANS_NONSEQ, "err_wr_id");
      xfer(32'hF000_0020, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "err_unmapped");
      xfer(32'hF000_0006, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "err_misalign");

      // Error followed by a read presented during ERR2
      HSEL = 1'b1; HADDR = 32'hF000_000C; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      step();
      bus_idle();
      HWDATA = 32'hFFFF_FFFF;
      chk("err_pipe/err1_ready", {31'd0, HREADYOUT}, 32'd0);
      chk("err_pipe/err1_resp", {31'd0, HRESP}, 32'd1);
      step();
      chk("err_pipe/err2_ready", {31'd0, HREADYOUT}, 32'd1);
      chk("err_pipe/err2_resp", {31'd0, HRESP}, 32'd1);
      HSEL = 1'b1; HADDR = 32'hF000_0008; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      step();
      chk("err_pipe/rd_ready", {31'd0, HREADYOUT}, 32'd1);
      chk("err_pipe/rd_resp", {31'd0, HRESP}, 32'd0);
      chk("err_pipe/rdata", HRDATA, m_clkdiv);
      bus_idle();
      step();
      chk_pins("err_pipe");

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         DROPPED = 10'($urandom);
         off = 8'($urandom_range(0, 31));
         sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         if (sz <= 2 && $urandom_range(0, 3) != 0) off = off & ~8'((1 << sz) - 1);
         case ($urandom_range(0, 5))
            0:       tr = HTRANS_IDLE;
            1:       tr = HTRANS_BUSY;
            2:       tr = HTRANS_SEQ;
            default: tr = HTRANS_NONSEQ;
         endcase
         a = {8'hF0, 16'($urandom), off};
         d = $urandom;
         xfer(a, 1'($urandom), sz, d, tr, $sformatf("rand%0d", n));
      end

      // Reset during a CLKDIV write data phase
      xfer(32'hF000_0008, 1'b1, HSIZE_WORD, 32'h0000_0009, HTRANS_NONSEQ, "pre_rst_wr");
      HSEL = 1'b1; HADDR = 32'hF000_0008; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      step();
      bus_idle();
      HWDATA = 32'h0000_0077;
      #2 RESETn = 1'b0;
      #1;
      m_reset();
      chk("rst_mid/clkdiv", {16'd0, CLKDIV}, 32'd4);
      chk("rst_mid/ready", {31'd0, HREADYOUT}, 32'd1);
      chk("rst_mid/resp", {31'd0, HRESP}, 32'd0);
      chk("rst_mid/state", {30'd0, dbg_state}, 32'd0);
      @(negedge CLK);
      #2 RESETn = 1'b1;
      @(negedge CLK);
      chk_pins("rst_mid/after");
      xfer(32'hF000_0008, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rst_mid/rd");
      xfer(32'hF000_0010, 1'b0, HSIZE_WORD, 32'd0, HTRANS_NONSEQ, "rst_mid/rd_scr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
